// File: rtl/grid_pkg.sv
// grid_pkg: maze geometry and tile codes shared by the scheduler, renderer and game logic.
package grid_pkg;
  localparam int GRID_COLS = 28;
  localparam int GRID_ROWS = 31;
  localparam int H_ORG = 208;
  localparam int V_ORG = 116;
  localparam int TILE_SHIFT = 3;
  typedef enum logic [3:0] {
    EMPTY = 4'd0,
    WALL = 4'd1,
    DOT = 4'd2,
    POWER = 4'd3
  } tile_t;
  // row * GRID_COLS built from shifted copies of row, one per set bit of the constant
  function automatic logic [15:0] times_cols(input logic [15:0] row);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++)
      if (GRID_COLS[i]) acc = acc + (row << i);
    return acc;
  endfunction
endpackage

// File: rtl/grid_mem_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick over req & ~mask; the pointer advances past the winner on accept.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] win,
  output logic          any
);
  logic [PW-1:0] ptr, idx;
  logic [N-1:0] elig;
  always_comb begin
    elig = req & ~mask;
    idx = ptr;
    win = ptr;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!any && elig[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    gnt = any ? N'(1) << win : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (accept && any) ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
endmodule

// File: rtl/grid_mem_scheduler.sv
// grid_mem_scheduler: shares the single-port tile RAM between fixed video fetch slots
// and round-robin game requesters.
module grid_mem_scheduler
  import grid_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic                        pixel_clk,
  input  logic                        rst_n,
  input  logic [10:0]                 hcounter,
  input  logic [10:0]                 vcounter,
  input  logic                        blank,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_flat,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_flat,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [DATA_W-1:0]           vid_tile,
  output logic                        vid_tile_valid,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic in_rows, video, vis_next, any, unused_blank;
  logic [10:0] hx;
  logic [7:0] row;
  logic [2:0] unused_lo;
  logic [ADDR_W-1:0] vaddr;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0] win, s1_idx, s2_idx;
  logic s1_vid, s1_rd, s2_vid, s2_rd;
  assign unused_blank = blank;
  // slots sit 3 pixels ahead of each span so the code lands as the span starts
  always_comb begin
    hx = hcounter - 11'(H_ORG - 3);
    {row, unused_lo} = vcounter - 11'(V_ORG);
    in_rows = vcounter >= 11'(V_ORG) && vcounter < 11'(V_ORG + 8 * GRID_ROWS);
    video = in_rows && hx < 11'(8 * GRID_COLS) && hx[2:0] == 3'd0;
    vaddr = ADDR_W'(times_cols(16'(row)) + 16'(hx[10:TILE_SHIFT]));
    vis_next = in_rows && hcounter >= 11'(H_ORG - 1) && hcounter < 11'(H_ORG + 8 * GRID_COLS - 1);
  end
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(pixel_clk),
    .rst_n(rst_n),
    .req(req),
    .mask(gnt),
    .accept(!video),
    .gnt(arb_gnt),
    .win(win),
    .any(any)
  );
  always_ff @(posedge pixel_clk)
    if (!rst_n) begin
      {gnt, rvalid, rdata, vid_tile, vid_tile_valid} <= '0;
      {ram_en, ram_we, ram_addr, ram_wdata} <= '0;
      {s1_vid, s1_rd, s1_idx, s2_vid, s2_rd, s2_idx} <= '0;
    end else begin
      gnt <= video ? '0 : arb_gnt;
      ram_en <= video || any;
      ram_we <= !video && any && we[win];
      ram_addr <= video ? vaddr : any ? addr_flat[win*ADDR_W +: ADDR_W] : ram_addr;
      ram_wdata <= !video && any ? wdata_flat[win*DATA_W +: DATA_W] : ram_wdata;
      s1_vid <= video;
      s1_rd <= !video && any && !we[win];
      s1_idx <= win;
      s2_vid <= s1_vid;
      s2_rd <= s1_rd;
      s2_idx <= s1_idx;
      rvalid <= s2_rd ? NUM_REQ'(1) << s2_idx : '0;
      rdata <= s2_rd ? ram_rdata : rdata;
      vid_tile_valid <= vis_next;
      vid_tile <= !vis_next ? '0 : s2_vid ? ram_rdata : vid_tile;
    end
endmodule

// File: tb/tb_grid_mem_scheduler.sv
// tb_grid_mem_scheduler: directed stimulus, a cycle-level scheduling model, and literal spot checks.
module tb_grid_mem_scheduler;
  logic pixel_clk = 1'b0;
  logic rst_n;
  logic [10:0] hcounter, vcounter;
  logic blank;
  logic [3:0] req, we, gnt, rvalid, rdata, vid_tile, ram_wdata, ram_rdata;
  logic [3:0] drop_pend = '0;
  logic [39:0] addr_flat;
  logic [15:0] wdata_flat;
  logic vid_tile_valid, ram_en, ram_we;
  logic [9:0] ram_addr;
  logic [3:0] ram [1024];
  bit ram_loaded = 1'b0;
  int total = 0, bad = 0;
  bit mon = 1'b0, auto_drop = 1'b1;
  typedef struct {bit v; bit vid; bit rd; int idx; int data;} st_t;
  st_t p1, p2;
  int mm [1024];
  int rr, e_rdata, e_tile, e_addr, e_wdata;
  logic [3:0] e_gnt, e_rvalid;
  bit e_valid, e_en, e_we;
  int m_hc, m_vc, m_hx, m_a, m_found;
  bit m_rows, m_video;
  logic [3:0] m_elig;
  int exp_rr [5] = '{1, 2, 4, 8, 1};
  int cnt_en, cnt_vid;

  function automatic int init_tile(int i);
    return i == 0 ? 5 : i == 31 ? 9 : i == 50 ? 7 : (i * 7) % 16;
  endfunction

  always #20 pixel_clk = ~pixel_clk;
  assign blank = hcounter >= 11'd640 || vcounter >= 11'd480;

  grid_mem_scheduler dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .hcounter(hcounter), .vcounter(vcounter),
    .blank(blank), .req(req), .we(we), .addr_flat(addr_flat), .wdata_flat(wdata_flat),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .vid_tile(vid_tile),
    .vid_tile_valid(vid_tile_valid), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // tile RAM: one cycle read latency
  always @(posedge pixel_clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 4'(init_tile(i));
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else ram_rdata <= ram[ram_addr];
    end
  end

  // model: what each output must be after every edge, from the scheduling rules
  initial begin
    for (int i = 0; i < 1024; i++) mm[i] = init_tile(i);
    p1 = '{0, 0, 0, 0, 0};
    p2 = p1;
    rr = 0; e_gnt = 0; e_rvalid = 0; e_rdata = 0; e_tile = 0; e_addr = 0; e_wdata = 0;
    e_valid = 0; e_en = 0; e_we = 0;
    forever begin
      @(posedge pixel_clk);
      if (!rst_n) begin
        p1 = '{0, 0, 0, 0, 0};
        p2 = p1;
        rr = 0; e_gnt = 0; e_rvalid = 0; e_rdata = 0; e_tile = 0; e_addr = 0; e_wdata = 0;
        e_valid = 0; e_en = 0; e_we = 0;
      end else begin
        m_hc = int'(hcounter);
        m_vc = int'(vcounter);
        e_rvalid = (p2.v && p2.rd) ? 4'b0001 << p2.idx : 4'b0000;
        if (p2.v && p2.rd) e_rdata = p2.data;
        m_rows = m_vc >= 116 && m_vc < 116 + 8 * 31;
        e_valid = m_rows && m_hc + 1 >= 208 && m_hc + 1 < 208 + 8 * 28;
        e_tile = !e_valid ? 0 : (p2.v && p2.vid) ? p2.data : e_tile;
        p2 = p1;
        p1 = '{0, 0, 0, 0, 0};
        m_hx = m_hc - 208 + 3;
        m_video = m_rows && m_hx >= 0 && m_hx < 8 * 28 && m_hx % 8 == 0;
        if (m_video) begin
          m_a = (m_vc - 116) / 8 * 28 + m_hx / 8;
          e_en = 1; e_we = 0; e_addr = m_a; e_gnt = 0;
          p1 = '{1, 1, 0, 0, mm[m_a]};
        end else begin
          m_elig = req & ~e_gnt;
          m_found = -1;
          for (int k = 0; k < 4; k++)
            if (m_found < 0 && m_elig[(rr + k) % 4]) m_found = (rr + k) % 4;
          e_gnt = 0;
          if (m_found >= 0) begin
            m_a = int'(addr_flat[m_found*10 +: 10]);
            e_gnt[m_found] = 1'b1;
            e_en = 1; e_we = we[m_found]; e_addr = m_a;
            e_wdata = int'(wdata_flat[m_found*4 +: 4]);
            if (we[m_found]) mm[m_a] = e_wdata;
            else p1 = '{1, 0, 1, m_found, mm[m_a]};
            rr = (m_found + 1) % 4;
          end else begin
            e_en = 0; e_we = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge pixel_clk)
    if (mon) begin
      chk("gnt", gnt, e_gnt);
      chk("rvalid", rvalid, e_rvalid);
      if (e_rvalid != 0) chk("rdata", rdata, e_rdata);
      chk("vid_tile", vid_tile, e_tile);
      chk("vid_tile_valid", vid_tile_valid, e_valid);
      chk("ram_en", ram_en, e_en);
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
    end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (drop_pend[i]) req[i] = 1'b0;
      drop_pend[i] = auto_drop && gnt[i];
    end
    if (hcounter == 11'd799) begin
      hcounter = 0;
      vcounter = (vcounter == 11'd524) ? 11'd0 : vcounter + 1'b1;
    end else hcounter = hcounter + 1'b1;
  endtask

  initial begin
    req = 0; we = 0; addr_flat = 0; wdata_flat = 0;
    hcounter = 0; vcounter = 100; rst_n = 0;
    tick();
    mon = 1;
    tick(); tick();
    chk("reset_gnt", gnt, 0);
    chk("reset_ram_en", ram_en, 0);
    chk("reset_vid_valid", vid_tile_valid, 0);
    // read granted, then reset lands on the grant cycle
    rst_n = 1;
    tick();
    req[0] = 1; addr_flat[9:0] = 10'd50;
    tick();
    chk("midread_gnt", gnt, 4'b0001);
    chk("midread_addr", ram_addr, 50);
    rst_n = 0; req[0] = 0; drop_pend = 0;
    tick();
    chk("midread_rvalid_a", rvalid, 0);
    tick();
    chk("midread_rvalid_b", rvalid, 0);
    chk("midread_ram_addr", ram_addr, 0);
    chk("midread_rdata", rdata, 0);
    chk("midread_ram_en", ram_en, 0);
    rst_n = 1;
    tick();
    chk("midread_rvalid_c", rvalid, 0);
    req = 4'b0011; addr_flat[19:10] = 10'd60;
    tick();
    chk("post_reset_gnt0", gnt, 4'b0001);
    tick();
    chk("post_reset_gnt1", gnt, 4'b0010);
    repeat (4) tick();
    // round-robin with every request held
    rst_n = 0;
    tick();
    rst_n = 1; auto_drop = 0;
    addr_flat = {10'd4, 10'd3, 10'd2, 10'd1};
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_gnt%0d", k), gnt, exp_rr[k]);
    end
    req = 0; auto_drop = 1;
    repeat (4) tick();
    // write then read back
    req[2] = 1; we[2] = 1; addr_flat[29:20] = 10'd100; wdata_flat[11:8] = 4'hA;
    tick();
    chk("wr_gnt", gnt, 4'b0100);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 100);
    chk("wr_ram_wdata", ram_wdata, 4'hA);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wr_no_rvalid", rvalid, 0);
    end
    we = 0;
    req[3] = 1; addr_flat[39:30] = 10'd100;
    tick();
    chk("rd_gnt", gnt, 4'b1000);
    tick(); tick();
    chk("rd_rvalid", rvalid, 4'b1000);
    chk("rd_rdata", rdata, 4'hA);
    // video line 116, first span
    req = 0; vcounter = 116; hcounter = 190;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hcounter == 206) begin
        chk("v116_en", ram_en, 1);
        chk("v116_addr", ram_addr, 0);
      end
      if (hcounter == 207) chk("v116_valid_pre", vid_tile_valid, 0);
      if (hcounter >= 208 && hcounter <= 215) begin
        chk("v116_tile", vid_tile, 5);
        chk("v116_valid", vid_tile_valid, 1);
      end
    end
    for (int i = 0; i < 800 && hcounter != 0; i++) tick();
    // line 124 with a read arriving on a video slot
    vcounter = 124; hcounter = 220;
    for (int i = 0; i < 20 && hcounter != 229; i++) tick();
    req[1] = 1; we[1] = 0; addr_flat[19:10] = 10'd50;
    tick();
    chk("col_vid_en", ram_en, 1);
    chk("col_vid_addr", ram_addr, 31);
    chk("col_vid_gnt", gnt, 0);
    tick();
    chk("col_gnt1", gnt, 4'b0010);
    chk("col_addr50", ram_addr, 50);
    tick();
    chk("col_tile9", vid_tile, 9);
    tick();
    chk("col_rvalid1", rvalid, 4'b0010);
    chk("col_rdata", rdata, 7);
    chk("col_tile9_hold", vid_tile, 9);
    // lines outside the maze
    req = 0; cnt_en = 0; cnt_vid = 0;
    vcounter = 100; hcounter = 0;
    repeat (800) begin
      tick();
      if (ram_en) cnt_en++;
      if (vid_tile_valid || vid_tile != 0) cnt_vid++;
    end
    vcounter = 364; hcounter = 0;
    repeat (800) begin
      tick();
      if (ram_en) cnt_en++;
      if (vid_tile_valid || vid_tile != 0) cnt_vid++;
    end
    chk("out_grid_ram_en", cnt_en, 0);
    chk("out_grid_vid", cnt_vid, 0);
    mon = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
